// File: rtl/mxint_acc_pkg.sv
// mxint_acc_pkg: shared width helpers and types for the MxInt accumulator.
package mxint_acc_pkg;

    function automatic int acc_width(input int in_man, input int depth);
        return in_man + $clog2(depth);
    endfunction

    function automatic int shift_width(input int out_man);
        return $clog2(out_man) + 1;
    endfunction

    localparam int DEF_OUT_MAN_WIDTH = acc_width(8, 4);

    // Shift amount for the default configuration; holds 0..OUT_MAN_WIDTH inclusive.
    typedef logic [shift_width(DEF_OUT_MAN_WIDTH)-1:0] shift_t;

endpackage

// File: rtl/mxint_align_shift.sv
// mxint_align_shift: signed right shift with sign-fill saturation; rounds half-up when MXINT_ACCUMULATOR_ROUND_EN is defined.
module mxint_align_shift
    import mxint_acc_pkg::*;
#(
    parameter int W  = DEF_OUT_MAN_WIDTH,
    parameter int SW = shift_width(W)
) (
    input  logic signed [W-1:0]  a,
    input  logic        [SW-1:0] s,
    output logic signed [W-1:0]  y
);

`ifdef MXINT_ACCUMULATOR_ROUND_EN
    logic        [W:0] bias;
    logic signed [W:0] ext;
    logic signed [W:0] sh;

    // One extra bit keeps the half-up bias from overflowing before the shift.
    always_comb begin
        bias = (s == '0) ? '0 : (W+1)'(1) << (s - SW'(1));
        ext  = {a[W-1], a} + bias;
        sh   = ext >>> s;
        y    = (s >= SW'(W)) ? '0 : sh[W-1:0];
    end
`else
    logic signed [W-1:0] sh;

    // Floor shift; shifting past the width leaves only the sign.
    always_comb begin
        sh = a >>> s;
        y  = (s >= SW'(W)) ? {W{a[W-1]}} : sh;
    end
`endif

endmodule

// File: rtl/mxint_accumulator.sv
// mxint_accumulator: sums IN_DEPTH MxInt blocks into one wide block aligned to the running max exponent; MXINT_ACCUMULATOR_ROUND_EN selects half-up alignment.
module mxint_accumulator
    import mxint_acc_pkg::*;
#(
    parameter int IN_MAN_WIDTH  = 8,
    parameter int IN_EXP_WIDTH  = 4,
    parameter int BLOCK_SIZE    = 4,
    parameter int IN_DEPTH      = 4,
    parameter int OUT_MAN_WIDTH = acc_width(IN_MAN_WIDTH, IN_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_MAN_WIDTH-1:0]  mdata_in [BLOCK_SIZE],
    input  logic [IN_EXP_WIDTH-1:0]  edata_in,
    input  logic                     data_in_valid,
    output logic                     data_in_ready,
    output logic [OUT_MAN_WIDTH-1:0] mdata_out [BLOCK_SIZE],
    output logic [IN_EXP_WIDTH-1:0]  edata_out,
    output logic                     data_out_valid,
    input  logic                     data_out_ready
);

    localparam int CW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int SW = shift_width(OUT_MAN_WIDTH);

    logic signed [OUT_MAN_WIDTH-1:0] acc    [BLOCK_SIZE];
    logic signed [OUT_MAN_WIDTH-1:0] ext    [BLOCK_SIZE];
    logic signed [OUT_MAN_WIDTH-1:0] acc_sh [BLOCK_SIZE];
    logic signed [OUT_MAN_WIDTH-1:0] in_sh  [BLOCK_SIZE];
    logic signed [OUT_MAN_WIDTH-1:0] nxt    [BLOCK_SIZE];
    logic [IN_EXP_WIDTH-1:0] acc_e, e_new, e_nxt, d_acc, d_in;
    logic [CW-1:0]           cnt;
    logic [SW-1:0]           sh_acc, sh_in;
    logic                    accept, first, last;

    // Handshake and exponent alignment; shift amounts clamp at the width so the shifter saturates.
    always_comb begin
        first         = cnt == '0;
        last          = cnt == CW'(IN_DEPTH - 1);
        data_in_ready = !data_out_valid || data_out_ready || !last;
        accept        = data_in_valid && data_in_ready;
        e_new         = (edata_in > acc_e) ? edata_in : acc_e;
        e_nxt         = first ? edata_in : e_new;
        d_acc         = e_new - acc_e;
        d_in          = e_new - edata_in;
        sh_acc        = (int'(d_acc) >= OUT_MAN_WIDTH) ? SW'(OUT_MAN_WIDTH) : SW'(d_acc);
        sh_in         = (int'(d_in) >= OUT_MAN_WIDTH) ? SW'(OUT_MAN_WIDTH) : SW'(d_in);
    end

    for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_lane
        assign ext[g] = OUT_MAN_WIDTH'($signed(mdata_in[g]));

        mxint_align_shift #(.W(OUT_MAN_WIDTH), .SW(SW)) u_acc_shift (
            .a (acc[g]),
            .s (sh_acc),
            .y (acc_sh[g])
        );

        mxint_align_shift #(.W(OUT_MAN_WIDTH), .SW(SW)) u_in_shift (
            .a (ext[g]),
            .s (sh_in),
            .y (in_sh[g])
        );

        assign nxt[g] = first ? ext[g] : acc_sh[g] + in_sh[g];
    end

    // Running partial sum and position within the group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            acc_e <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) acc[i] <= '0;
        end else if (accept) begin
            cnt   <= last ? '0 : cnt + CW'(1);
            acc_e <= e_nxt;
            for (int i = 0; i < BLOCK_SIZE; i++) acc[i] <= nxt[i];
        end
    end

    // Output register: loads on the completing accept, otherwise drains on ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_valid <= 1'b0;
            edata_out      <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) mdata_out[i] <= '0;
        end else if (accept && last) begin
            data_out_valid <= 1'b1;
            edata_out      <= e_nxt;
            for (int i = 0; i < BLOCK_SIZE; i++) mdata_out[i] <= nxt[i];
        end else if (data_out_ready) begin
            data_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mxint_accumulator.sv
// tb_mxint_accumulator: scoreboard bench for a depth-4 and a depth-2 accumulator instance.
module tb_mxint_accumulator;

    localparam int IM = 8;
    localparam int EW = 4;
    localparam int BS = 2;
    localparam int OA = 10;
    localparam int OB = 9;

    typedef struct {
        int m0;
        int m1;
        int e;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [IM-1:0] a_mi [BS];
    logic [IM-1:0] b_mi [BS];
    logic [OA-1:0] a_mo [BS];
    logic [OB-1:0] b_mo [BS];
    logic [EW-1:0] a_ei, b_ei, a_eo, b_eo;
    logic a_vi, b_vi, a_ri, b_ri, a_vo, b_vo, a_ro, b_ro;

    exp_t qa[$];
    exp_t qb[$];
    exp_t xa, xb, t;
    int checks = 0;
    int failures = 0;
    bit rnd_done = 1'b0;

    mxint_accumulator #(.IN_MAN_WIDTH(IM), .IN_EXP_WIDTH(EW), .BLOCK_SIZE(BS), .IN_DEPTH(4)) u_dut_a (
        .clk(clk), .rst(rst), .mdata_in(a_mi), .edata_in(a_ei), .data_in_valid(a_vi), .data_in_ready(a_ri),
        .mdata_out(a_mo), .edata_out(a_eo), .data_out_valid(a_vo), .data_out_ready(a_ro)
    );

    mxint_accumulator #(.IN_MAN_WIDTH(IM), .IN_EXP_WIDTH(EW), .BLOCK_SIZE(BS), .IN_DEPTH(2)) u_dut_b (
        .clk(clk), .rst(rst), .mdata_in(b_mi), .edata_in(b_ei), .data_in_valid(b_vi), .data_in_ready(b_ri),
        .mdata_out(b_mo), .edata_out(b_eo), .data_out_valid(b_vo), .data_out_ready(b_ro)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic push(input bit sel, input int m0, input int m1, input int e);
        t.m0 = m0;
        t.m1 = m1;
        t.e  = e;
        if (sel) qb.push_back(t);
        else qa.push_back(t);
    endtask

    function automatic int ashr(input int x, input int s);
`ifdef MXINT_ACCUMULATOR_ROUND_EN
        if (s == 0) return x;
        if (s >= OA) return 0;
        return (x + (1 << (s - 1))) >>> s;
`else
        if (s >= OA) return (x < 0) ? -1 : 0;
        return x >>> s;
`endif
    endfunction

    task automatic send(input bit sel, input int m0, input int m1, input int e);
        bit ok = 1'b0;
        if (sel) begin
            b_vi = 1'b1; b_mi[0] = IM'(m0); b_mi[1] = IM'(m1); b_ei = EW'(e);
        end else begin
            a_vi = 1'b1; a_mi[0] = IM'(m0); a_mi[1] = IM'(m1); a_ei = EW'(e);
        end
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = sel ? b_ri : a_ri;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            check("send_timeout", 0, 1);
        end
        if (sel) b_vi = 1'b0;
        else a_vi = 1'b0;
    endtask

    // Pop and compare each output the bench consumes on instance a.
    always @(negedge clk) begin
        if (!rst && a_vo && a_ro) begin
            if (qa.size() == 0) check("a_unexpected", 1, 0);
            else begin
                xa = qa.pop_front();
                check("a_m0", $signed(a_mo[0]), xa.m0);
                check("a_m1", $signed(a_mo[1]), xa.m1);
                check("a_e", a_eo, xa.e);
            end
        end
    end

    // Pop and compare each output the bench consumes on instance b.
    always @(negedge clk) begin
        if (!rst && b_vo && b_ro) begin
            if (qb.size() == 0) check("b_unexpected", 1, 0);
            else begin
                xb = qb.pop_front();
                check("b_m0", $signed(b_mo[0]), xb.m0);
                check("b_m1", $signed(b_mo[1]), xb.m1);
                check("b_e", b_eo, xb.e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ma0, ma1, me, mc, en, m0, m1, e;
        a_vi = 1'b0; b_vi = 1'b0; a_ro = 1'b1; b_ro = 1'b1;
        a_ei = '0; b_ei = '0;
        for (int i = 0; i < BS; i++) begin a_mi[i] = '0; b_mi[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", a_vo, 0);
        check("rst_m0", a_mo[0], 0);
        check("rst_e", a_eo, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", a_ri, 1);

        push(0, 4, -8, 7);
        for (int i = 0; i < 4; i++) begin
            send(0, 1, -2, 7);
            if (i == 2) check("eq_lat_early", a_vo, 0);
        end
        check("eq_lat", a_vo, 1);

        push(0, -512, 508, 3);
        for (int i = 0; i < 4; i++) send(0, -128, 127, 3);

        push(1, 17, 0, 9);
        send(1, 64, 0, 7);
        send(1, 1, 0, 9);
`ifdef MXINT_ACCUMULATOR_ROUND_EN
        push(1, 2, 0, 6);
`else
        push(1, 1, 0, 6);
`endif
        send(1, 3, 0, 5);
        send(1, 0, 0, 6);
`ifdef MXINT_ACCUMULATOR_ROUND_EN
        push(1, 10, 0, 15);
`else
        push(1, 9, 0, 15);
`endif
        send(1, -5, 0, 0);
        send(1, 10, 0, 15);

        repeat (2) @(posedge clk);
        #1;
        a_ro = 1'b0;
        push(0, 8, 12, 1);
        for (int i = 0; i < 4; i++) send(0, 2, 3, 1);
        for (int i = 0; i < 3; i++) send(0, 1, -1, 2);
        check("bp_hold_v", a_vo, 1);
        check("bp_hold_m0", $signed(a_mo[0]), 8);
        check("bp_hold_e", a_eo, 1);
        a_vi = 1'b1; a_mi[0] = IM'(1); a_mi[1] = IM'(-1); a_ei = EW'(2);
        @(negedge clk);
        check("bp_stall", a_ri, 0);
        @(posedge clk);
        #1;
        check("bp_stable", $signed(a_mo[1]), 12);
        push(0, 4, -4, 2);
        a_ro = 1'b1;
        send(0, 1, -1, 2);
        check("bp_b2b", a_vo, 1);
        @(posedge clk);
        #1;
        check("bp_drain", qa.size(), 0);

        a_ro = 1'b0;
        for (int i = 0; i < 6; i++) send(0, 5, 5, 4);
        check("pre_rst_valid", a_vo, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", a_vo, 0);
        check("mid_rst_m0", a_mo[0], 0);
        check("mid_rst_m1", a_mo[1], 0);
        check("mid_rst_e", a_eo, 0);
        qa.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_ro = 1'b1;
        push(0, 4, 4, 0);
        for (int i = 0; i < 4; i++) send(0, 1, 1, 0);

        mc = 0; ma0 = 0; ma1 = 0; me = 0;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    m0 = int'($urandom_range(0, 255)) - 128;
                    m1 = int'($urandom_range(0, 255)) - 128;
                    e  = int'($urandom_range(0, 15));
                    if (mc == 0) begin
                        ma0 = m0; ma1 = m1; me = e;
                    end else begin
                        en  = (e > me) ? e : me;
                        ma0 = ashr(ma0, en - me) + ashr(m0, en - e);
                        ma1 = ashr(ma1, en - me) + ashr(m1, en - e);
                        me  = en;
                    end
                    if (mc == 3) push(0, ma0, ma1, me);
                    mc = (mc + 1) % 4;
                    send(0, m0, m1, e);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #2;
                    a_ro = (rnd_done != 0) || ($urandom_range(0, 1) != 0);
                end
            end
        join
        a_ro = 1'b1;
        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
        #1;
        check("final_qa", qa.size(), 0);
        check("final_qb", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
